dmem_pipe: RTL and testbench

Parametrised, latency-configurable data memory for the RV32IM core family, succeeding the single-cycle combinational data memory. It accepts one load/store request at a time over a valid/ready handshake and performs RISC-V byte/half/word accesses with sign or zero extension. It returns a one-cycle response pulse after a programmable number of wait states, and flags misaligned, out-of-range and illegal-funct3 accesses as faults. It sits between the pipelined core's MEM stage and on-chip data RAM.

---
 rtl/dmem_pipe.sv | 180 ++++++++++++++++++
 tb/tb_dmem_pipe.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_pipe.sv
// Latency-configurable RV32 data memory: valid/ready request, byte/half/word
// loads and stores, programmable wait states, one-cycle response pulse with fault flag.
module dmem_pipe #(
  parameter int XLEN        = 32,
  parameter int FUNCT3_W    = 3,
  parameter int DMEM_W      = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                clk,
  input  logic                n_reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [FUNCT3_W-1:0] funct3,
  input  logic [XLEN-1:0]     addr,
  input  logic [XLEN-1:0]     write_data,
  output logic                rsp_valid,
  output logic [XLEN-1:0]     rsp_data,
  output logic                rsp_fault
);

  localparam int AW = $clog2(DMEM_W);
  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES);

  localparam logic [FUNCT3_W-1:0] F3_B  = FUNCT3_W'(0);
  localparam logic [FUNCT3_W-1:0] F3_H  = FUNCT3_W'(1);
  localparam logic [FUNCT3_W-1:0] F3_W  = FUNCT3_W'(2);
  localparam logic [FUNCT3_W-1:0] F3_BU = FUNCT3_W'(4);
  localparam logic [FUNCT3_W-1:0] F3_HU = FUNCT3_W'(5);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t              state, state_nx;
  logic [3:0]          cnt;
  logic                lat_we;
  logic [FUNCT3_W-1:0] lat_f3;
  logic [XLEN-1:0]     lat_addr;
  logic [XLEN-1:0]     lat_wdata;

  logic [XLEN-1:0]     mem [DMEM_W];

  logic                accept;
  logic                acc_go;
  logic                acc_we;
  logic [FUNCT3_W-1:0] acc_f3;
  logic [XLEN-1:0]     acc_addr;
  logic [XLEN-1:0]     acc_wdata;
  logic [AW-1:0]       acc_idx;
  logic                acc_fault;
  logic                f3_legal;
  logic                misalign;
  logic                out_of_range;
  logic [3:0]          be;
  logic [XLEN-1:0]     wd_lanes;
  logic [XLEN-1:0]     rd_word;
  logic [7:0]          sel_byte;
  logic [15:0]         sel_half;
  logic [XLEN-1:0]     ld_data;

  assign req_ready = (state != WAIT);
  assign rsp_valid = (state == RESP);
  // A request presented while reset is held must never be taken.
  assign accept    = req_valid && req_ready && n_reset;

  // With zero wait states the access happens on the acceptance edge itself,
  // so it must use the live request rather than the latched copy.
  always_comb begin
    acc_go    = 1'b0;
    acc_we    = lat_we;
    acc_f3    = lat_f3;
    acc_addr  = lat_addr;
    acc_wdata = lat_wdata;
    if (WAIT_CYCLES == 0) begin
      acc_go    = accept;
      acc_we    = req_we;
      acc_f3    = funct3;
      acc_addr  = addr;
      acc_wdata = write_data;
    end else begin
      acc_go    = (state == WAIT) && (cnt == 4'd1);
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = (WAIT_CYCLES == 0) ? RESP : WAIT;
      WAIT:    if (cnt == 4'd1) state_nx = RESP;
      RESP:    state_nx = accept ? ((WAIT_CYCLES == 0) ? RESP : WAIT) : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign acc_idx = acc_addr[AW+1:2];

  always_comb begin
    f3_legal     = acc_we ? (acc_f3 == F3_B || acc_f3 == F3_H || acc_f3 == F3_W)
                          : (acc_f3 == F3_B || acc_f3 == F3_H || acc_f3 == F3_W ||
                             acc_f3 == F3_BU || acc_f3 == F3_HU);
    misalign     = ((acc_f3 == F3_H || acc_f3 == F3_HU) && acc_addr[0]) ||
                   ((acc_f3 == F3_W) && (acc_addr[1:0] != 2'b00));
    out_of_range = (acc_addr >> 2) >= XLEN'(DMEM_W);
    acc_fault    = !f3_legal || misalign || out_of_range;
  end

  // Stores replicate the narrow datum across lanes; byte enables pick the target.
  always_comb begin
    be       = 4'b1111;
    wd_lanes = acc_wdata;
    case (acc_f3)
      F3_B: begin
        be       = 4'b0001 << acc_addr[1:0];
        wd_lanes = {4{acc_wdata[7:0]}};
      end
      F3_H: begin
        be       = acc_addr[1] ? 4'b1100 : 4'b0011;
        wd_lanes = {2{acc_wdata[15:0]}};
      end
      default: begin
        be       = 4'b1111;
        wd_lanes = acc_wdata;
      end
    endcase
  end

  always_comb begin
    rd_word  = mem[acc_idx];
    sel_byte = rd_word[{acc_addr[1:0], 3'b000} +: 8];
    sel_half = acc_addr[1] ? rd_word[31:16] : rd_word[15:0];
    case (acc_f3)
      F3_B:    ld_data = {{(XLEN-8){sel_byte[7]}}, sel_byte};
      F3_BU:   ld_data = {{(XLEN-8){1'b0}}, sel_byte};
      F3_H:    ld_data = {{(XLEN-16){sel_half[15]}}, sel_half};
      F3_HU:   ld_data = {{(XLEN-16){1'b0}}, sel_half};
      F3_W:    ld_data = rd_word;
      default: ld_data = '0;
    endcase
  end

  // NOTE: the storage array has no reset; clearing it would turn the RAM into
  // a register file. State is safe because acc_go cannot fire during reset.
  always_ff @(posedge clk) begin
    if (acc_go && acc_we && !acc_fault) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[acc_idx][8*i +: 8] <= wd_lanes[8*i +: 8];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_we    <= 1'b0;
      lat_f3    <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rsp_data  <= '0;
      rsp_fault <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        lat_we    <= req_we;
        lat_f3    <= funct3;
        lat_addr  <= addr;
        lat_wdata <= write_data;
        cnt       <= CNT_INIT;
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (acc_go) begin
        rsp_fault <= acc_fault;
        rsp_data  <= (acc_fault || acc_we) ? '0 : ld_data;
      end
    end
  end

endmodule

// File: tb/tb_dmem_pipe.sv
// Directed bench for dmem_pipe: three instances cover WAIT_CYCLES = 1, 0 and 3,
// with hand-computed expectations for data, faults, latency and reset behaviour.
module tb_dmem_pipe;

  logic        clk;
  logic        n_reset;
  logic        req_we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] write_data;

  logic        v1, v0, v3;
  logic        rdy1, rdy0, rdy3;
  logic        rv1, rv0, rv3;
  logic [31:0] rd1, rd0, rd3;
  logic        rf1, rf0, rf3;

  int          sel;
  logic        s_rv;
  logic [31:0] s_rd;
  logic        s_rf;

  int checks   = 0;
  int failures = 0;

  dmem_pipe #(.WAIT_CYCLES(1)) u_dut1 (
    .clk(clk), .n_reset(n_reset), .req_valid(v1), .req_ready(rdy1),
    .req_we(req_we), .funct3(funct3), .addr(addr), .write_data(write_data),
    .rsp_valid(rv1), .rsp_data(rd1), .rsp_fault(rf1)
  );

  dmem_pipe #(.WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .n_reset(n_reset), .req_valid(v0), .req_ready(rdy0),
    .req_we(req_we), .funct3(funct3), .addr(addr), .write_data(write_data),
    .rsp_valid(rv0), .rsp_data(rd0), .rsp_fault(rf0)
  );

  dmem_pipe #(.WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .n_reset(n_reset), .req_valid(v3), .req_ready(rdy3),
    .req_we(req_we), .funct3(funct3), .addr(addr), .write_data(write_data),
    .rsp_valid(rv3), .rsp_data(rd3), .rsp_fault(rf3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    s_rv = rv1;
    s_rd = rd1;
    s_rf = rf1;
    case (sel)
      0:       begin s_rv = rv0; s_rd = rd0; s_rf = rf0; end
      3:       begin s_rv = rv3; s_rd = rd3; s_rf = rf3; end
      default: begin s_rv = rv1; s_rd = rd1; s_rf = rf1; end
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_valid(input int s, input logic val);
    case (s)
      0:       v0 = val;
      3:       v3 = val;
      default: v1 = val;
    endcase
  endtask

  // Issue one request and wait (bounded) for its response pulse.
  task automatic xact(input int s, input logic we, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output logic flt, output int lat);
    @(negedge clk);
    sel        = s;
    req_we     = we;
    funct3     = f3;
    addr       = a;
    write_data = wd;
    set_valid(s, 1'b1);
    @(posedge clk);
    #1;
    set_valid(s, 1'b0);
    lat = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (s_rv) break;
    end
    rd  = s_rd;
    flt = s_rf;
  endtask

  task automatic run(input int s, input int exp_lat, input string tag,
                     input logic we, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] exp_d, input logic exp_f);
    logic [31:0] rd;
    logic        flt;
    int          lat;
    xact(s, we, f3, a, wd, rd, flt, lat);
    check({tag, "_lat"},   32'(lat), 32'(exp_lat));
    check({tag, "_data"},  rd, exp_d);
    check({tag, "_fault"}, {31'b0, flt}, {31'b0, exp_f});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_reset    = 1'b0;
    sel        = 1;
    v1         = 1'b0;
    v0         = 1'b0;
    v3         = 1'b0;
    req_we     = 1'b0;
    funct3     = 3'd0;
    addr       = 32'h0;
    write_data = 32'h0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", {31'b0, rv1},  32'd0);
    check("rst_ready", {31'b0, rdy1}, 32'd1);
    check("rst_data",  rd1,           32'h0);
    check("rst_fault", {31'b0, rf1},  32'd0);
    n_reset = 1'b1;

    // WAIT_CYCLES = 1: word store/load round trip
    run(1, 2, "sw_10", 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0);
    run(1, 2, "lw_10", 1'b0, 3'd2, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0);
    @(negedge clk);
    check("hold_valid_low", {31'b0, rv1}, 32'd0);
    check("hold_data",      rd1,          32'hDEADBEEF);

    // A store presented while the block is busy must be ignored
    @(negedge clk);
    sel = 1; req_we = 1'b0; funct3 = 3'd2; addr = 32'h10; v1 = 1'b1;
    @(negedge clk);
    check("busy_ready_low", {31'b0, rdy1}, 32'd0);
    req_we = 1'b1; write_data = 32'h0;
    @(negedge clk);
    v1 = 1'b0;
    check("busy_rsp_valid", {31'b0, rv1}, 32'd1);
    check("busy_rsp_data",  rd1,          32'hDEADBEEF);
    run(1, 2, "lw_10_again", 1'b0, 3'd2, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

    // Byte/half loads with sign and zero extension
    run(1, 2, "sw_20",  1'b1, 3'd2, 32'h20, 32'h80FF7F01, 32'h0,        1'b0);
    run(1, 2, "lb_23",  1'b0, 3'd0, 32'h23, 32'h0,        32'hFFFFFF80, 1'b0);
    run(1, 2, "lbu_23", 1'b0, 3'd4, 32'h23, 32'h0,        32'h00000080, 1'b0);
    run(1, 2, "lh_22",  1'b0, 3'd1, 32'h22, 32'h0,        32'hFFFF80FF, 1'b0);
    run(1, 2, "lhu_20", 1'b0, 3'd5, 32'h20, 32'h0,        32'h00007F01, 1'b0);

    // Partial stores touch only the addressed lanes
    run(1, 2, "sw_20b", 1'b1, 3'd2, 32'h20, 32'h11223344, 32'h0,        1'b0);
    run(1, 2, "sb_21",  1'b1, 3'd0, 32'h21, 32'h123456AA, 32'h0,        1'b0);
    run(1, 2, "lw_20a", 1'b0, 3'd2, 32'h20, 32'h0,        32'h1122AA44, 1'b0);
    run(1, 2, "sh_22",  1'b1, 3'd1, 32'h22, 32'h9876BEEF, 32'h0,        1'b0);
    run(1, 2, "lw_20b", 1'b0, 3'd2, 32'h20, 32'h0,        32'hBEEFAA44, 1'b0);

    // Faults: misaligned, out of range, illegal funct3
    run(1, 2, "lw_02_mis",  1'b0, 3'd2, 32'h02,   32'h0, 32'h0,        1'b1);
    run(1, 2, "lw_10_ok",   1'b0, 3'd2, 32'h10,   32'h0, 32'hDEADBEEF, 1'b0);
    run(1, 2, "lw_oor",     1'b0, 3'd2, 32'h1000, 32'h0, 32'h0,        1'b1);
    run(1, 2, "lw_10_ok2",  1'b0, 3'd2, 32'h10,   32'h0, 32'hDEADBEEF, 1'b0);
    run(1, 2, "ld_f3_3",    1'b0, 3'd3, 32'h10,   32'h0, 32'h0,        1'b1);
    run(1, 2, "sh_01_mis",  1'b1, 3'd1, 32'h01,   32'hFFFF, 32'h0,     1'b1);
    run(1, 2, "sw_04",      1'b1, 3'd2, 32'h04,   32'h01020304, 32'h0, 1'b0);
    run(1, 2, "sw_06_mis",  1'b1, 3'd2, 32'h06,   32'h12345678, 32'h0, 1'b1);
    run(1, 2, "lw_04",      1'b0, 3'd2, 32'h04,   32'h0, 32'h01020304, 1'b0);

    // WAIT_CYCLES = 0: continuous requests, one response per cycle
    @(negedge clk);
    sel = 0; req_we = 1'b1; funct3 = 3'd2; addr = 32'h30; write_data = 32'h5A5A5A5A; v0 = 1'b1;
    @(negedge clk);
    check("w0_sw_valid", {31'b0, rv0},  32'd1);
    check("w0_sw_ready", {31'b0, rdy0}, 32'd1);
    check("w0_sw_data",  rd0,           32'h0);
    req_we = 1'b0;
    @(negedge clk);
    check("w0_lw_valid", {31'b0, rv0}, 32'd1);
    check("w0_lw_data",  rd0,          32'h5A5A5A5A);
    funct3 = 3'd4; addr = 32'h31;
    @(negedge clk);
    check("w0_lbu_valid", {31'b0, rv0}, 32'd1);
    check("w0_lbu_data",  rd0,          32'h0000005A);
    funct3 = 3'd2; addr = 32'h32;
    @(negedge clk);
    check("w0_mis_valid", {31'b0, rv0}, 32'd1);
    check("w0_mis_fault", {31'b0, rf0}, 32'd1);
    check("w0_mis_data",  rd0,          32'h0);
    v0 = 1'b0;
    @(negedge clk);
    check("w0_idle_valid", {31'b0, rv0}, 32'd0);
    check("w0_fault_hold", {31'b0, rf0}, 32'd1);

    // WAIT_CYCLES = 3: reset during WAIT discards the pending store
    run(3, 4, "w3_sw_40", 1'b1, 3'd2, 32'h40, 32'h13572468, 32'h0, 1'b0);
    @(negedge clk);
    sel = 3; req_we = 1'b1; funct3 = 3'd2; addr = 32'h40; write_data = 32'hCAFEF00D; v3 = 1'b1;
    @(posedge clk);
    #1;
    v3 = 1'b0;
    @(negedge clk);
    check("w3_ready_wait", {31'b0, rdy3}, 32'd0);
    @(negedge clk);
    n_reset = 1'b0;
    #1;
    check("w3_rst_valid", {31'b0, rv3},  32'd0);
    check("w3_rst_ready", {31'b0, rdy3}, 32'd1);
    v3 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    v3 = 1'b0;
    n_reset = 1'b1;
    @(negedge clk);
    check("w3_no_accept_in_reset", {31'b0, rv3}, 32'd0);
    run(3, 4, "w3_lw_40", 1'b0, 3'd2, 32'h40, 32'h0, 32'h13572468, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
